// File: rtl/edit_mem_read_ctrl_pkg.sv
// Package for the edit-memory read controller.
// Holds the default widths, the tag width helper and the FSM state encoding
// shared by the top and the tag pipe.
package edit_mem_read_ctrl_pkg;

    localparam int EM_BUF_PTR_NBITS     = 8;
    localparam int EM_BUF_PTR_LSB_NBITS = 2;
    localparam int DATA_PATH_NBITS      = 32;
    localparam int PORT_ID_NBITS        = 3;
    localparam int NPORTS               = 1 << PORT_ID_NBITS;
    localparam int RD_LAT_DFLT          = 3;
    localparam int CREDIT_NBITS_DFLT    = 4;
    localparam int CREDIT_MAX_DFLT      = 8;

    // Tag layout, MSB first: {valid, port id, sop, eop}
    function automatic int tag_nbits(input int id_nbits);
        return 1 + id_nbits + 2;
    endfunction

    localparam int TAG_NBITS = tag_nbits(PORT_ID_NBITS);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rd_state_e;

endpackage

// File: rtl/edit_mem_read_ctrl_tag_pipe.sv
// em_rd_tag_pipe: fixed-latency delay line for request tags.
// A tag entering on in_i appears on out_o DEPTH cycles later. Reset clears
// every stage, so in-flight tags are discarded.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   in_i   tag loaded every cycle (valid bit is part of the tag)
//   out_o  tag from DEPTH cycles ago
module em_rd_tag_pipe #(
    parameter int W     = 6,
    parameter int DEPTH = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/edit_mem_read_ctrl.sv
// edit_mem_read_ctrl: read-side initiator for the edit-memory packet buffer.
// Takes one segment descriptor at a time, expands it into one data_req beat
// per line (gated by per-port line credits), tracks each beat through a
// fixed-latency tag pipe and routes the returned line to its egress port.
//
// Handshake: a descriptor transfers on a rising clock edge where both
// desc_valid_i and desc_ready_o are high. desc_ready_o is high only in IDLE
// (and low while rst_i is high); it does not depend on desc_valid_i.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   desc_*_i / desc_ready_o      segment descriptor input
//   port_credit_ret_i            one line credit back per set bit, per port
//   data_req_*_o                 registered line read request
//   edit_mem_ack_i/_rdata_i      returned line, RD_LAT cycles after data_req
//   port_data_*_o                line delivered to egress, one cycle after ack
//   err_unexp_ack_o              sticky: ack/tag mismatch or credit overflow
//   dbg_state_o                  current FSM state (0 IDLE, 1 ISSUE)
module edit_mem_read_ctrl
    import edit_mem_read_ctrl_pkg::*;
#(
    parameter int BPTR_NBITS     = EM_BUF_PTR_NBITS,
    parameter int BPTR_LSB_NBITS = EM_BUF_PTR_LSB_NBITS,
    parameter int DATA_NBITS     = DATA_PATH_NBITS,
    parameter int ID_NBITS       = PORT_ID_NBITS,
    parameter int RD_LAT         = RD_LAT_DFLT,
    parameter int CREDIT_NBITS   = CREDIT_NBITS_DFLT,
    parameter int CREDIT_MAX     = CREDIT_MAX_DFLT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      desc_valid_i,
    output logic                      desc_ready_o,
    input  logic [ID_NBITS-1:0]       desc_dst_port_id_i,
    input  logic [BPTR_NBITS-1:0]     desc_buf_ptr_i,
    input  logic [BPTR_LSB_NBITS-1:0] desc_nlines_m1_i,
    input  logic                      desc_sop_i,
    input  logic                      desc_eop_i,
    input  logic [(1<<ID_NBITS)-1:0]  port_credit_ret_i,
    output logic                      data_req_o,
    output logic [ID_NBITS-1:0]       data_req_dst_port_id_o,
    output logic                      data_req_sop_o,
    output logic                      data_req_eop_o,
    output logic [BPTR_NBITS-1:0]     data_req_buf_ptr_o,
    output logic [BPTR_LSB_NBITS-1:0] data_req_buf_ptr_lsb_o,
    input  logic                      edit_mem_ack_i,
    input  logic [DATA_NBITS-1:0]     edit_mem_rdata_i,
    output logic                      port_data_valid_o,
    output logic [ID_NBITS-1:0]       port_data_id_o,
    output logic                      port_data_sop_o,
    output logic                      port_data_eop_o,
    output logic [DATA_NBITS-1:0]     port_data_o,
    output logic                      err_unexp_ack_o,
    output logic                      dbg_state_o
);

    localparam int NP = 1 << ID_NBITS;
    localparam int TW = tag_nbits(ID_NBITS);
    localparam logic [CREDIT_NBITS-1:0] CMAX = CREDIT_NBITS'(CREDIT_MAX);

    rd_state_e state_q, state_d;

    logic [ID_NBITS-1:0]       port_q;
    logic [BPTR_NBITS-1:0]     ptr_q;
    logic [BPTR_LSB_NBITS-1:0] nlm1_q, line_q;
    logic                      sop_q, eop_q;

    logic [NP-1:0][CREDIT_NBITS-1:0] credit_q, credit_d;
    logic                            sat_err;

    logic accept, issue, last_line;

    logic [TW-1:0] tag_in, tag_out;

    logic                  pdv_q, pd_sop_q, pd_eop_q, err_q;
    logic [ID_NBITS-1:0]   pd_id_q;
    logic [DATA_NBITS-1:0] pd_data_q;

    assign desc_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign accept       = desc_ready_o && desc_valid_i;
    assign issue        = (state_q == ST_ISSUE) && (credit_q[port_q] != '0);
    assign last_line    = (line_q == nlm1_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (desc_valid_i) state_d = ST_ISSUE;
            ST_ISSUE: if (issue && last_line) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Latched descriptor and line counter. The counter stops being used once
    // the last line issues, so an all-ones segment never walks into the next
    // buffer even though line_q itself wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            port_q <= '0;
            ptr_q  <= '0;
            nlm1_q <= '0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
            line_q <= '0;
        end else if (accept) begin
            port_q <= desc_dst_port_id_i;
            ptr_q  <= desc_buf_ptr_i;
            nlm1_q <= desc_nlines_m1_i;
            sop_q  <= desc_sop_i;
            eop_q  <= desc_eop_i;
            line_q <= '0;
        end else if (issue) begin
            line_q <= line_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_req_o             <= 1'b0;
            data_req_dst_port_id_o <= '0;
            data_req_sop_o         <= 1'b0;
            data_req_eop_o         <= 1'b0;
            data_req_buf_ptr_o     <= '0;
            data_req_buf_ptr_lsb_o <= '0;
        end else begin
            data_req_o <= issue;
            if (issue) begin
                data_req_dst_port_id_o <= port_q;
                data_req_sop_o         <= sop_q && (line_q == '0);
                data_req_eop_o         <= eop_q && last_line;
                data_req_buf_ptr_o     <= ptr_q;
                data_req_buf_ptr_lsb_o <= line_q;
            end
        end
    end

    // Credits: an issue and a return on the same port cancel out. A return
    // into a full counter is dropped and flagged.
    always_comb begin
        credit_d = credit_q;
        sat_err  = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (issue && (port_q == ID_NBITS'(p)) && !port_credit_ret_i[p]) begin
                credit_d[p] = credit_q[p] - 1'b1;
            end else if (!(issue && (port_q == ID_NBITS'(p))) && port_credit_ret_i[p]) begin
                if (credit_q[p] >= CMAX) sat_err = 1'b1;
                else                     credit_d[p] = credit_q[p] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NP; p++) credit_q[p] <= CMAX;
        end else begin
            credit_q <= credit_d;
        end
    end

    // The tag enters from the registered request, so it leaves the pipe in
    // the same cycle the responder acks that request.
    assign tag_in = {data_req_o, data_req_dst_port_id_o, data_req_sop_o, data_req_eop_o};

    em_rd_tag_pipe #(
        .W     (TW),
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (tag_in),
        .out_o (tag_out)
    );

    // Delivery follows the ack alone; a missing or extra ack only raises the
    // sticky error so the egress side still sees exactly what memory returned.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pdv_q     <= 1'b0;
            pd_id_q   <= '0;
            pd_sop_q  <= 1'b0;
            pd_eop_q  <= 1'b0;
            pd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pdv_q     <= edit_mem_ack_i;
            pd_id_q   <= tag_out[TW-2 -: ID_NBITS];
            pd_sop_q  <= tag_out[1];
            pd_eop_q  <= tag_out[0];
            pd_data_q <= edit_mem_rdata_i;
            err_q     <= err_q | (edit_mem_ack_i ^ tag_out[TW-1]) | sat_err;
        end
    end

    assign port_data_valid_o = pdv_q;
    assign port_data_id_o    = pd_id_q;
    assign port_data_sop_o   = pd_sop_q;
    assign port_data_eop_o   = pd_eop_q;
    assign port_data_o       = pd_data_q;
    assign err_unexp_ack_o   = err_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_edit_mem_read_ctrl.sv
module tb_edit_mem_read_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [2:0]  desc_port = '0;
    logic [7:0]  desc_ptr = '0;
    logic [1:0]  desc_nlm1 = '0;
    logic        desc_sop = 1'b0;
    logic        desc_eop = 1'b0;
    logic [7:0]  credit_ret = '0;
    logic        data_req;
    logic [2:0]  req_port;
    logic        req_sop, req_eop;
    logic [7:0]  req_ptr;
    logic [1:0]  req_lsb;
    logic        ack;
    logic [31:0] rdata;
    logic        pdv;
    logic [2:0]  pd_id;
    logic        pd_sop, pd_eop;
    logic [31:0] pd_data;
    logic        err;
    logic        dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    edit_mem_read_ctrl #(
        .BPTR_NBITS(8), .BPTR_LSB_NBITS(2), .DATA_NBITS(32), .ID_NBITS(3),
        .RD_LAT(3), .CREDIT_NBITS(4), .CREDIT_MAX(8)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
        .desc_dst_port_id_i(desc_port), .desc_buf_ptr_i(desc_ptr),
        .desc_nlines_m1_i(desc_nlm1), .desc_sop_i(desc_sop), .desc_eop_i(desc_eop),
        .port_credit_ret_i(credit_ret),
        .data_req_o(data_req), .data_req_dst_port_id_o(req_port),
        .data_req_sop_o(req_sop), .data_req_eop_o(req_eop),
        .data_req_buf_ptr_o(req_ptr), .data_req_buf_ptr_lsb_o(req_lsb),
        .edit_mem_ack_i(ack), .edit_mem_rdata_i(rdata),
        .port_data_valid_o(pdv), .port_data_id_o(pd_id),
        .port_data_sop_o(pd_sop), .port_data_eop_o(pd_eop), .port_data_o(pd_data),
        .err_unexp_ack_o(err), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check task ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] line_data(input logic [7:0] ptr, input logic [1:0] lsb);
        return 32'hD000_0000 | {22'd0, ptr, lsb};
    endfunction

    // ---------------- model responder: ack 3 cycles after data_req ----------------
    logic        r_v [3];
    logic [31:0] r_d [3];
    logic        stray_ack = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin r_v[i] <= 1'b0; r_d[i] <= '0; end
        end else begin
            r_v[0] <= data_req;
            r_d[0] <= line_data(req_ptr, req_lsb);
            for (int i = 1; i < 3; i++) begin r_v[i] <= r_v[i-1]; r_d[i] <= r_d[i-1]; end
        end
    end
    assign ack   = r_v[2] | stray_ack;
    assign rdata = r_d[2];

    // ---------------- monitor + scoreboard ----------------
    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  port;
        logic        sop;
        logic        eop;
        logic [7:0]  ptr;
        logic [1:0]  lsb;
    } req_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  id;
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } exp_t;

    req_t req_log[$];
    exp_t exp_q[$];
    logic stray_ok = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (pdv) begin
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pd_cycle", cyc, e.cyc);
                    check("pd_id", pd_id, e.id);
                    check("pd_sop", pd_sop, e.sop);
                    check("pd_eop", pd_eop, e.eop);
                    check("pd_data", pd_data, e.data);
                end else if (!stray_ok) begin
                    check("unexp_port_data", pdv, 1'b0);
                end
            end
            if (data_req) begin
                req_log.push_back('{cyc: cyc, port: req_port, sop: req_sop, eop: req_eop,
                                    ptr: req_ptr, lsb: req_lsb});
                exp_q.push_back('{cyc: cyc + 4, id: req_port, sop: req_sop, eop: req_eop,
                                  data: line_data(req_ptr, req_lsb)});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_desc(input logic [2:0] port, input logic [7:0] ptr,
                             input logic [1:0] nlm1, input logic sop, input logic eop);
        int t;
        t = 0;
        @(negedge clk);
        desc_port  = port;
        desc_ptr   = ptr;
        desc_nlm1  = nlm1;
        desc_sop   = sop;
        desc_eop   = eop;
        desc_valid = 1'b1;
        while (!desc_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!desc_ready) check("desc_timeout", desc_ready, 1'b1);
        @(posedge clk);
        #1 desc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic credit_pulse(input int p);
        @(negedge clk);
        credit_ret[p] = 1'b1;
        @(negedge clk);
        credit_ret = '0;
    endtask

    task automatic check_beat(input string tag, input int i, input logic [2:0] port,
                              input logic [7:0] ptr, input logic [1:0] lsb,
                              input logic sop, input logic eop);
        if (i >= req_log.size()) begin
            check({tag, "_missing"}, req_log.size(), i + 1);
        end else begin
            check({tag, "_port"}, req_log[i].port, port);
            check({tag, "_ptr"},  req_log[i].ptr,  ptr);
            check({tag, "_lsb"},  req_log[i].lsb,  lsb);
            check({tag, "_sop"},  req_log[i].sop,  sop);
            check({tag, "_eop"},  req_log[i].eop,  eop);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // reset values
        repeat (2) @(negedge clk);
        check("rst_desc_ready", desc_ready, 1'b0);
        check("rst_data_req", data_req, 1'b0);
        check("rst_pdv", pdv, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_desc_ready", desc_ready, 1'b1);
        check("idle_state", dbg_state, 1'b0);
        check("rst_credit0", dut.credit_q[0], 4'd8);
        check("rst_credit7", dut.credit_q[7], 4'd8);

        // 1: full-buffer segment, port 2
        req_log.delete();
        send_desc(3'd2, 8'h15, 2'd3, 1'b1, 1'b1);
        idle(20);
        check("s1_nbeats", req_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_beat("s1", i, 3'd2, 8'h15, 2'(i), i == 0, i == 3);
            if (i < req_log.size())
                check("s1_cycle", req_log[i].cyc, req_log[0].cyc + i);
        end
        check("s1_credit2", dut.credit_q[2], 4'd4);
        check("s1_drain", exp_q.size(), 0);

        // 2: port 5, two 4-line segments exhaust credits, third stalls
        req_log.delete();
        send_desc(3'd5, 8'h20, 2'd3, 1'b1, 1'b0);
        send_desc(3'd5, 8'h21, 2'd3, 1'b0, 1'b1);
        send_desc(3'd5, 8'h22, 2'd1, 1'b1, 1'b1);
        idle(12);
        check("s2_nbeats", req_log.size(), 8);
        for (int i = 0; i < 8; i++)
            check_beat("s2", i, 3'd5, (i < 4) ? 8'h20 : 8'h21, 2'(i % 4), i == 0, i == 7);
        if (req_log.size() >= 5) check("s2_bubble", req_log[4].cyc - req_log[3].cyc, 2);
        check("s2_stall_state", dbg_state, 1'b1);
        check("s2_credit5", dut.credit_q[5], 4'd0);
        check("s2_stall_req", data_req, 1'b0);
        credit_pulse(5);
        idle(6);
        check("s2_one_beat", req_log.size(), 9);
        check_beat("s2_ret1", 8, 3'd5, 8'h22, 2'd0, 1'b1, 1'b0);
        check("s2_still_issue", dbg_state, 1'b1);
        credit_pulse(5);
        idle(6);
        check("s2_two_beats", req_log.size(), 10);
        check_beat("s2_ret2", 9, 3'd5, 8'h22, 2'd1, 1'b0, 1'b1);
        check("s2_back_idle", dbg_state, 1'b0);
        check("s2_credit5_end", dut.credit_q[5], 4'd0);

        // 3: back-to-back descriptors on ports 0 and 1
        idle(10);
        req_log.delete();
        send_desc(3'd0, 8'h30, 2'd1, 1'b1, 1'b1);
        send_desc(3'd1, 8'h31, 2'd1, 1'b1, 1'b1);
        idle(20);
        check("s3_nbeats", req_log.size(), 4);
        check_beat("s3", 0, 3'd0, 8'h30, 2'd0, 1'b1, 1'b0);
        check_beat("s3", 1, 3'd0, 8'h30, 2'd1, 1'b0, 1'b1);
        check_beat("s3", 2, 3'd1, 8'h31, 2'd0, 1'b1, 1'b0);
        check_beat("s3", 3, 3'd1, 8'h31, 2'd1, 1'b0, 1'b1);
        if (req_log.size() == 4) begin
            check("s3_seg_a", req_log[1].cyc - req_log[0].cyc, 1);
            check("s3_bubble", req_log[2].cyc - req_log[1].cyc, 2);
        end
        check("s3_credit0", dut.credit_q[0], 4'd6);
        check("s3_credit1", dut.credit_q[1], 4'd6);
        check("s3_drain", exp_q.size(), 0);

        // 4: issue and credit return on port 3 in the same cycle
        req_log.delete();
        send_desc(3'd3, 8'h40, 2'd0, 1'b1, 1'b1);
        credit_ret[3] = 1'b1;     // the issue decision is made in this cycle
        @(posedge clk);
        #1 credit_ret = '0;
        idle(10);
        check("s4_nbeats", req_log.size(), 1);
        check_beat("s4", 0, 3'd3, 8'h40, 2'd0, 1'b1, 1'b1);
        check("s4_credit3", dut.credit_q[3], 4'd8);
        check("s4_err", err, 1'b0);

        // 5: stray ack with an empty tag pipe
        @(negedge clk);
        stray_ok  = 1'b1;
        stray_ack = 1'b1;
        @(posedge clk);
        #1 stray_ack = 1'b0;
        check("s5_err_set", err, 1'b1);
        check("s5_pdv_follows_ack", pdv, 1'b1);
        idle(5);
        check("s5_err_sticky", err, 1'b1);
        stray_ok = 1'b0;

        // 6: reset in the middle of a segment on port 4
        req_log.delete();
        send_desc(3'd4, 8'h50, 2'd3, 1'b1, 1'b1);
        idle(2);
        check("s6_mid_segment", data_req, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("s6_rst_req", data_req, 1'b0);
        check("s6_rst_pdv", pdv, 1'b0);
        check("s6_rst_ready", desc_ready, 1'b0);
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("s6_ready", desc_ready, 1'b1);
        check("s6_state", dbg_state, 1'b0);
        check("s6_credit4", dut.credit_q[4], 4'd8);
        check("s6_credit5", dut.credit_q[5], 4'd8);
        check("s6_err_clr", err, 1'b0);
        req_log.delete();
        idle(12);
        check("s6_no_beats", req_log.size(), 0);
        check("s6_no_err", err, 1'b0);

        // 7: credit return into a full counter
        credit_pulse(6);
        check("s7_sat_err", err, 1'b1);
        check("s7_credit6", dut.credit_q[6], 4'd8);
        check("final_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
